// File: rtl/oled_frame_scheduler.sv
// rtl/oled_frame_scheduler.sv - arbitrates ad-hoc command bytes and framebuffer refresh bursts onto one SPI byte path
// Optional OLED_DIRTY_SKIP_EN: timer refreshes only when fb_dirty, else pulses frame_skipped.
module oled_frame_scheduler #(
  parameter int FRAME_BYTES    = 1024,
  parameter int ADDR_W         = 10,
  parameter int REFRESH_PERIOD = 900_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              frame_req,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_byte,
  output logic              cmd_ready,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic              tx_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_dc,
  input  logic              tx_ready,
  output logic              busy,
  output logic              frame_done
`ifdef OLED_DIRTY_SKIP_EN
  ,
  input  logic              fb_dirty,
  output logic              frame_skipped
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CMD_SEND = 3'd1;
  localparam logic [2:0] WIN_SEND = 3'd2;
  localparam logic [2:0] FB_ADDR  = 3'd3;
  localparam logic [2:0] FB_WAIT  = 3'd4;
  localparam logic [2:0] FB_SEND  = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam int TW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [TW-1:0]     TLAST    = TW'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(FRAME_BYTES - 1);

  logic [2:0]        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              pending_q, pending_d;
  logic              last_frame_q, last_frame_d;
  logic [2:0]        widx_q, widx_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_dc_q, tx_dc_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              tick, set_pending, cmd_go, frame_go;
`ifdef OLED_DIRTY_SKIP_EN
  logic              skipped_q, skipped_d;
`endif

  // Column window 0..127, page window 0..7
  function automatic logic [7:0] win_byte(input logic [2:0] i);
    case (i)
      3'd0:    win_byte = 8'h21;
      3'd1:    win_byte = 8'h00;
      3'd2:    win_byte = 8'h7F;
      3'd3:    win_byte = 8'h22;
      3'd4:    win_byte = 8'h00;
      3'd5:    win_byte = 8'h07;
      default: win_byte = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    widx_d       = widx_q;
    idx_d        = idx_q;
    last_frame_d = last_frame_q;
    tx_valid_d   = tx_valid_q;
    tx_byte_d    = tx_byte_q;
    tx_dc_d      = tx_dc_q;
    frame_done_d = 1'b0;

    tick = (REFRESH_PERIOD != 0) && (timer_q == TLAST);
    if (REFRESH_PERIOD == 0 || tick) timer_d = '0;
    else                             timer_d = timer_q + TW'(1);
`ifdef OLED_DIRTY_SKIP_EN
    set_pending = frame_req | (tick & fb_dirty);
    skipped_d   = tick & ~fb_dirty;
`else
    set_pending = frame_req | tick;
`endif

    // cmd_ready_q already encodes the round-robin outcome, so a handshake always wins
    cmd_go   = (state_q == IDLE) && cmd_valid && cmd_ready_q;
    frame_go = (state_q == IDLE) && !cmd_go && init_done && pending_q &&
               (!cmd_valid || !last_frame_q);
    pending_d = (pending_q && !frame_go) || set_pending;

    case (state_q)
      IDLE: begin
        if (cmd_go) begin
          tx_valid_d   = 1'b1;
          tx_byte_d    = cmd_byte;
          tx_dc_d      = 1'b0;
          last_frame_d = 1'b0;
          state_d      = CMD_SEND;
        end else if (frame_go) begin
          widx_d       = 3'd0;
          tx_valid_d   = 1'b1;
          tx_byte_d    = win_byte(3'd0);
          tx_dc_d      = 1'b0;
          last_frame_d = 1'b1;
          state_d      = WIN_SEND;
        end
      end
      CMD_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      WIN_SEND: begin
        if (tx_ready) begin
          if (widx_q == 3'd5) begin
            tx_valid_d = 1'b0;
            idx_d      = '0;
            state_d    = FB_ADDR;
          end else begin
            widx_d    = widx_q + 3'd1;
            tx_byte_d = win_byte(widx_q + 3'd1);
          end
        end
      end
      FB_ADDR: state_d = FB_WAIT;
      FB_WAIT: begin
        // fb_addr was stable through FB_ADDR, so RAM data is valid now
        tx_valid_d = 1'b1;
        tx_byte_d  = fb_data;
        tx_dc_d    = 1'b1;
        state_d    = FB_SEND;
      end
      FB_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            frame_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = FB_ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE) && init_done && (!pending_d || last_frame_d);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      pending_q    <= 1'b0;
      last_frame_q <= 1'b1;
      widx_q       <= 3'd0;
      idx_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_byte_q    <= 8'h00;
      tx_dc_q      <= 1'b0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef OLED_DIRTY_SKIP_EN
      skipped_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      last_frame_q <= last_frame_d;
      widx_q       <= widx_d;
      idx_q        <= idx_d;
      tx_valid_q   <= tx_valid_d;
      tx_byte_q    <= tx_byte_d;
      tx_dc_q      <= tx_dc_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef OLED_DIRTY_SKIP_EN
      skipped_q    <= skipped_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign fb_addr    = idx_q;
  assign tx_valid   = tx_valid_q;
  assign tx_byte    = tx_byte_q;
  assign tx_dc      = tx_dc_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
`ifdef OLED_DIRTY_SKIP_EN
  assign frame_skipped = skipped_q;
`endif

endmodule

// File: tb/tb_oled_frame_scheduler.sv
// tb/tb_oled_frame_scheduler.sv - self-checking bench: byte-stream scoreboard on dut0, refresh timer on dut1
module tb_oled_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut0: FRAME_BYTES=4, timer disabled
  logic       rst0, init0, freq0, cval0, crdy0, txv0, txdc0, txr0, busy0, done0;
  logic [7:0] cbyte0, fb_data0, txb0;
  logic [1:0] addr0;
  // dut1: FRAME_BYTES=4, REFRESH_PERIOD=50
  logic       rst1, init1, freq1, cval1, crdy1, txv1, txdc1, txr1, busy1, done1;
  logic [7:0] cbyte1, fb_data1, txb1;
  logic [1:0] addr1;
`ifdef OLED_DIRTY_SKIP_EN
  logic       dirty0, dirty1, skip0, skip1;
`endif

  oled_frame_scheduler #(.FRAME_BYTES(4), .ADDR_W(2), .REFRESH_PERIOD(0)) dut0 (
    .clk(clk), .rst(rst0), .init_done(init0), .frame_req(freq0),
    .cmd_valid(cval0), .cmd_byte(cbyte0), .cmd_ready(crdy0),
    .fb_addr(addr0), .fb_data(fb_data0),
    .tx_valid(txv0), .tx_byte(txb0), .tx_dc(txdc0), .tx_ready(txr0),
    .busy(busy0), .frame_done(done0)
`ifdef OLED_DIRTY_SKIP_EN
    , .fb_dirty(dirty0), .frame_skipped(skip0)
`endif
  );

  oled_frame_scheduler #(.FRAME_BYTES(4), .ADDR_W(2), .REFRESH_PERIOD(50)) dut1 (
    .clk(clk), .rst(rst1), .init_done(init1), .frame_req(freq1),
    .cmd_valid(cval1), .cmd_byte(cbyte1), .cmd_ready(crdy1),
    .fb_addr(addr1), .fb_data(fb_data1),
    .tx_valid(txv1), .tx_byte(txb1), .tx_dc(txdc1), .tx_ready(txr1),
    .busy(busy1), .frame_done(done1)
`ifdef OLED_DIRTY_SKIP_EN
    , .fb_dirty(dirty1), .frame_skipped(skip1)
`endif
  );

  logic [7:0] mem [4];
  always @(posedge clk) fb_data0 <= mem[addr0];
  always @(posedge clk) fb_data1 <= 8'h5A;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected byte stream: a frame is the fixed window preamble then the RAM contents
  typedef struct {
    logic       dc;
    logic [7:0] b;
    bit         first;
    bit         last;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_frame();
    logic [7:0] win [6];
    win = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
    for (int i = 0; i < 6; i++) exp_q.push_back('{1'b0, win[i], i == 0, 1'b0});
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, mem[i], 1'b0, i == 3});
  endtask

  task automatic push_cmd(input logic [7:0] b);
    exp_q.push_back('{1'b0, b, 1'b0, 1'b0});
  endtask

  // Scoreboard / protocol monitor for dut0
  int         ncyc = 0, t21 = 0, tdone = 0, n_done = 0, a2_cnt = 0;
  bit         done_exp = 0, in_frame = 0, stall_prev = 0;
  logic [7:0] prev_b;
  logic       prev_dc;

  always @(negedge clk) begin
    if (rst0) begin
      stall_prev = 0;
      done_exp   = 0;
      in_frame   = 0;
    end else begin
      exp_t e;
      ncyc++;
      check("frame_done", done0, done_exp);
      done_exp = 0;
      if (done0) begin
        in_frame = 0;
        n_done++;
        tdone = ncyc;
      end
      if (in_frame) check("cmd_ready_in_frame", crdy0, 1'b0);
      if (stall_prev) begin
        check("stall_valid", txv0, 1'b1);
        check("stall_byte", txb0, prev_b);
        check("stall_dc", txdc0, prev_dc);
      end
      if (txv0) check("busy_with_tx", busy0, 1'b1);
      if (txv0 && txr0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tx", {txdc0, txb0}, 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", txb0, e.b);
          check("tx_dc", txdc0, e.dc);
          if (e.first) begin
            in_frame = 1;
            t21 = ncyc;
          end
          if (e.last) done_exp = 1;
          if (e.dc && e.b == 8'hA2) a2_cnt++;
        end
      end
`ifdef OLED_DIRTY_SKIP_EN
      check("skip_no_timer", skip0, 1'b0);
`endif
      stall_prev = txv0 && !txr0;
      prev_b  = txb0;
      prev_dc = txdc0;
    end
  end

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busy0 == 1'b0) break;
    end
    check(nm, {30'd0, exp_q.size() != 0, busy0}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_txv"}, txv0, 1'b0);
    check({nm, "_txb"}, txb0, 8'h00);
    check({nm, "_txdc"}, txdc0, 1'b0);
    check({nm, "_crdy"}, crdy0, 1'b0);
    check({nm, "_addr"}, addr0, 2'd0);
    check({nm, "_busy"}, busy0, 1'b0);
    check({nm, "_done"}, done0, 1'b0);
  endtask

  // dut1 refresh timer: edges counted from reset release, wraps on every 50th edge
  int cyc1 = 0;
  int starts[$];
  bit busy1_prev = 0;
  bit t1_done = 0;
  always @(posedge clk) if (rst1) cyc1 = 0; else cyc1++;
  always @(negedge clk) if (!rst1) begin
    if (busy1 && !busy1_prev) starts.push_back(cyc1);
    busy1_prev = busy1;
  end

  initial begin
    int init_edge, next_start;
    init1 = 0; freq1 = 0; cval1 = 0; cbyte1 = 8'h00; txr1 = 1;
`ifdef OLED_DIRTY_SKIP_EN
    dirty1 = 1;
`endif
    wait (rst1 == 1'b0);
    while (cyc1 < 210) begin @(posedge clk); #1; end
    init1 = 1;
    init_edge = cyc1 + 1;
    while (cyc1 < 300) begin @(posedge clk); #1; end
    next_start = ((init_edge / 50) + 1) * 50 + 1;
    check("timer_frame_count", starts.size(), 2);
    if (starts.size() >= 1) check("timer_first_start", starts[0], init_edge);
    if (starts.size() >= 2) check("timer_second_start", starts[1], next_start);
    check("timer_first_start_literal", init_edge, 211);
    t1_done = 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a2_before, done_before;
    bit found;
    mem = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    rst0 = 1; rst1 = 1;
    init0 = 1; freq0 = 0; cval0 = 0; cbyte0 = 8'h00; txr0 = 1;
`ifdef OLED_DIRTY_SKIP_EN
    dirty0 = 0;
`endif
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst0 = 0; rst1 = 0;
    repeat (3) begin @(posedge clk); #1; end

    // Basic frame on request
    push_frame();
    freq0 = 1;
    @(posedge clk); #1;
    freq0 = 0;
    wait_idle("frame1_idle");
    check("frame1_done_count", n_done, 1);
    check("frame1_cadence", tdone - t21, 18);

    // Command and frame requested together; command wins after reset-era FRAME grant
    push_cmd(8'h81);
    push_frame();
    push_cmd(8'hA5);
    cval0 = 1; cbyte0 = 8'h81; freq0 = 1;
    @(negedge clk);
    check("rr_cmd_ready_first", crdy0, 1'b1);
    @(posedge clk); #1;
    freq0 = 0; cbyte0 = 8'hA5;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (crdy0) begin found = 1; break; end
    end
    check("second_cmd_ready_seen", found, 1'b1);
    check("second_cmd_after_frame_done", n_done, 2);
    @(posedge clk); #1;
    cval0 = 0;
    wait_idle("rr_idle");

    // Backpressure on data byte A2
    a2_before = a2_cnt;
    push_frame();
    freq0 = 1;
    @(posedge clk); #1;
    freq0 = 0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txv0 && txdc0 && txb0 == 8'hA1) begin found = 1; break; end
    end
    check("stall_reach_a1", found, 1'b1);
    @(posedge clk); #1;
    txr0 = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txv0 && txb0 == 8'hA2) begin found = 1; break; end
    end
    check("stall_reach_a2", found, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("stall_hold_valid", txv0, 1'b1);
      check("stall_hold_byte", txb0, 8'hA2);
      check("stall_hold_dc", txdc0, 1'b1);
      @(posedge clk); #1;
      if (k == 4) txr0 = 1;
      else @(negedge clk);
    end
    wait_idle("stall_idle");
    check("a2_once", a2_cnt - a2_before, 1);

    // Reset in the middle of the window preamble
    push_frame();
    freq0 = 1;
    @(posedge clk); #1;
    freq0 = 0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txv0 && txr0 && !txdc0 && txb0 == 8'h7F) begin found = 1; break; end
    end
    check("rst_reach_7f", found, 1'b1);
    @(posedge clk); #1;
    rst0 = 1;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    @(posedge clk); #1;
    rst0 = 0;
    repeat (2) begin @(posedge clk); #1; end
    done_before = n_done;
    push_frame();
    freq0 = 1;
    @(posedge clk); #1;
    freq0 = 0;
    wait_idle("after_rst_idle");
    check("after_rst_done", n_done - done_before, 1);

    while (!t1_done) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
